// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety island core-local peripheral path.
package safety_island_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } bridge_state_e;

   // Also returned by the TCLS error slave, so both sides agree on the pattern.
   localparam logic [31:0] ERR_VAL = 32'hBADCAB1E;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } cl_reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } cl_reg_rsp_t;

endpackage

// File: rtl/safety_cl_periph_bridge.sv
// Core data-side req/gnt/rvalid to single-outstanding register interface,
// with a watchdog that answers with an error when a peripheral never responds.
module safety_cl_periph_bridge
   import safety_island_pkg::*;
#(
   parameter int unsigned          AddrWidth     = 32,
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          TimeoutCycles = 255,
   parameter logic [DataWidth-1:0] ErrVal        = ERR_VAL,
   parameter type                  reg_req_t     = cl_reg_req_t,
   parameter type                  reg_rsp_t     = cl_reg_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o,
   output reg_req_t               reg_req_o,
   input  reg_rsp_t               reg_rsp_i,
   output logic                   timeout_o
);

   localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam int unsigned LastInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
   localparam logic [CntW-1:0] CntLast = CntW'(LastInt);

   bridge_state_e          state_q, state_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic                   we_q, we_d;
   logic [DataWidth/8-1:0] be_q, be_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   to_q, to_d;
   logic                   timeout_hit;

   // Fires on the TimeoutCycles-th valid cycle without ready.
   assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      gnt_o   = 1'b0;
      unique case (state_q)
         IDLE, RESP: begin
            gnt_o   = req_i;
            state_d = IDLE;
            if (req_i) begin
               addr_d  = addr_i;
               we_d    = we_i;
               be_d    = be_i;
               wdata_d = wdata_i;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (reg_rsp_i.ready) begin
               rdata_d = we_q ? '0 : reg_rsp_i.rdata;
               err_d   = reg_rsp_i.error;
               state_d = RESP;
            end else if (timeout_hit) begin
               rdata_d = ErrVal;
               err_d   = 1'b1;
               to_d    = 1'b1;
               state_d = RESP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      reg_req_o = '0;
      if (state_q == ACCESS) begin
         reg_req_o.valid = 1'b1;
         reg_req_o.addr  = addr_q;
         reg_req_o.write = we_q;
         reg_req_o.wdata = wdata_q;
         reg_req_o.wstrb = we_q ? be_q : '0;
      end
   end

   assign rvalid_o  = (state_q == RESP);
   assign rdata_o   = rvalid_o ? rdata_q : '0;
   assign err_o     = rvalid_o & err_q;
   assign timeout_o = to_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_safety_cl_periph_bridge.sv
// Randomized scoreboard bench for the core-local peripheral bridge.
module tb_safety_cl_periph_bridge;
   import safety_island_pkg::*;

   localparam int TO = 8;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst_i, req_i, we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i, wdata_i;
   logic        gnt_o, rvalid_o, err_o, timeout_o;
   logic [31:0] rdata_o;
   cl_reg_req_t reg_req_o;
   cl_reg_rsp_t reg_rsp_i;

   safety_cl_periph_bridge #(.TimeoutCycles(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
      .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          d;
      logic [31:0] rd;
      logic        perr;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
      int unsigned due;
   } exp_t;

   txn_t plan_q[$];
   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   bit in_reset = 1'b0;

   function automatic int mn(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Peripheral model: answers on the d-th valid cycle of each transaction.
   initial begin
      txn_t cur;
      int   n;
      bit   prev;
      cur = '{default: 0};
      n = 0;
      prev = 1'b0;
      reg_rsp_i = '0;
      forever begin
         @(negedge clk);
         if (reg_req_o.valid) begin
            if (!prev) begin
               n = 0;
               if (plan_q.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  cur = plan_q.pop_front();
               end
            end
            n++;
            check("req_fields",
                  {reg_req_o.addr, reg_req_o.write, reg_req_o.wdata, reg_req_o.wstrb},
                  {cur.addr, cur.we, cur.wdata, cur.we ? cur.be : 4'b0});
            reg_rsp_i.ready = (n == cur.d);
            reg_rsp_i.rdata = cur.rd;
            reg_rsp_i.error = cur.perr;
         end else begin
            if (prev && !in_reset) check("valid_len", n, mn(cur.d, TO));
            reg_rsp_i.ready = 1'b0;
            reg_rsp_i.rdata = $urandom;
            reg_rsp_i.error = 1'($urandom);
         end
         prev = reg_req_o.valid;
      end
   end

   // Response monitor.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst_i) begin
         check("gnt_in_access", gnt_o & reg_req_o.valid, 0);
         if (rvalid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rvalid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rdata", rdata_o, e.rdata);
               check("err", err_o, e.err);
               check("timeout", timeout_o, e.to);
               check("latency_cycle", cyc, e.due);
            end
         end else begin
            check("quiet_outputs", {timeout_o, err_o, rdata_o}, 0);
         end
      end
   end

   task automatic issue(txn_t t);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      req_i   = 1'b1;
      we_i    = t.we;
      be_i    = t.be;
      addr_i  = t.addr;
      wdata_i = t.wdata;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (gnt_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("grant_timeout", 0, 1);
      end else begin
         plan_q.push_back(t);
         e.to    = (t.d > TO);
         e.rdata = e.to ? 32'hBADCAB1E : (t.we ? 32'h0 : t.rd);
         e.err   = e.to ? 1'b1 : t.perr;
         e.due   = cyc + mn(t.d, TO) + 1;
         exp_q.push_back(e);
      end
      @(negedge clk);
      req_i   = 1'b0;
      we_i    = 1'($urandom);
      be_i    = 4'($urandom);
      addr_i  = $urandom;
      wdata_i = $urandom;
   endtask

   function automatic txn_t mk(logic [31:0] a, logic w, logic [3:0] b,
                               logic [31:0] wd, int d, logic [31:0] rd, logic pe);
      txn_t t;
      t.addr = a; t.we = w; t.be = b; t.wdata = wd;
      t.d = d; t.rd = rd; t.perr = pe;
      return t;
   endfunction

   function automatic txn_t rnd();
      int sel;
      int d;
      sel = $urandom_range(0, 9);
      d = (sel < 6) ? $urandom_range(1, 4) :
          (sel < 8) ? $urandom_range(5, TO) : NEVER;
      return mk($urandom, 1'($urandom), 4'($urandom), $urandom, d, $urandom,
                ($urandom_range(0, 5) == 0));
   endfunction

   initial begin
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = '0;
      addr_i = '0; wdata_i = '0;
      repeat (2) @(negedge clk);
      #2;
      check("reset_gnt", gnt_o, 0);
      check("reset_rvalid", rvalid_o, 0);
      check("reset_reg_req", reg_req_o, 0);
      check("reset_timeout", timeout_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      issue(mk(32'h0020_1000, 1'b0, 4'hF, 32'h0, 1, 32'h1234_5678, 1'b0));
      repeat (3) @(negedge clk);
      issue(mk(32'h0020_1004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3, 32'h5555_AAAA, 1'b0));
      repeat (4) @(negedge clk);
      issue(mk(32'h0020_2000, 1'b0, 4'hF, 32'h0, NEVER, 32'h0, 1'b0));
      repeat (12) @(negedge clk);
      issue(mk(32'h0020_1008, 1'b0, 4'hF, 32'h0, 1, 32'hCAFE_0001, 1'b0));
      repeat (3) @(negedge clk);
      issue(mk(32'h0020_1010, 1'b0, 4'hF, 32'h0, 1, 32'h0000_0011, 1'b0));
      issue(mk(32'h0020_1014, 1'b0, 4'hF, 32'h0, 1, 32'h0000_0022, 1'b0));
      repeat (3) @(negedge clk);
      issue(mk(32'h0020_1018, 1'b0, 4'hF, 32'h0, 2, 32'h0BAD_0BAD, 1'b1));
      repeat (3) @(negedge clk);
      issue(mk(32'h0020_101C, 1'b0, 4'hF, 32'h0, TO, 32'h7777_8888, 1'b0));
      repeat (12) @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         issue(rnd());
         if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      repeat (15) @(negedge clk);

      issue(mk(32'h0020_3000, 1'b1, 4'hF, 32'h1111_2222, NEVER, 32'h0, 1'b0));
      @(negedge clk);
      rst_i = 1'b1;
      in_reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst_i = 1'b0;
      #2;
      check("post_reset_valid", reg_req_o.valid, 0);
      check("post_reset_rvalid", rvalid_o, 0);
      @(negedge clk);
      #3;
      in_reset = 1'b0;
      @(negedge clk);
      issue(mk(32'h0020_1020, 1'b0, 4'hF, 32'h0, 2, 32'hFEED_F00D, 1'b0));

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) check("drain_pending", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
